// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the 5-stage pipeline control slice.
//               Holds the stall/flush FSM state encoding, the NOP
//               instruction word and the default memory wait limit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Stall/flush sequencer states
    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    // Word loaded into a pipeline register when it is flushed
    localparam logic [31:0] c_nop_instr = 32'h0000_0000;

    // Default number of consecutive mem_busy cycles tolerated
    localparam int c_wait_max_default = 64;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. Sticks at all-ones instead of
//               wrapping; i_clear has priority over i_inc.
// Ports       : clk      - clock, rising edge
//               i_clear  - synchronous clear to zero
//               i_inc    - increment request
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central stall/flush sequencer for the 5-stage MIPS pipeline.
//               Arbitrates memory busy (freeze), taken branch (flush) and
//               load-use (one bubble) requests, drives the PC and pipeline
//               register enables/flushes, keeps saturating performance
//               counters and a sticky memory-timeout error.
// Ports       : clk, reset          - clock / synchronous active-high reset
//               load_use           - hazard unit stall request
//               branch_taken_mem   - branch in MEM resolved taken
//               mem_busy           - data memory not done this cycle
//               pc_write           - PC load enable
//               if_id_write        - IF/ID load enable
//               if_id_flush        - IF/ID load NOP
//               id_ex_flush        - ID/EX load NOP (bubble)
//               ex_mem_flush       - EX/MEM load NOP
//               pipe_en            - ID/EX, EX/MEM, MEM/WB enable
//               mem_timeout        - sticky memory timeout error
//               stall_cycles       - saturating count of pc_write=0 cycles
//               flush_events       - saturating count of branch flushes
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_MAX = c_wait_max_default,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use,
    input  logic             branch_taken_mem,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int                  c_wcnt_w    = $clog2(WAIT_MAX + 1);
    // Busy cycle that, if still busy, makes the count reach WAIT_MAX
    localparam logic [c_wcnt_w-1:0] c_wait_last = c_wcnt_w'(WAIT_MAX - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_wcnt_w-1:0] r_wait_cnt;
    logic [c_wcnt_w-1:0] w_wait_cnt_nxt;
    logic                w_timeout_set;
    logic                r_guard;
    logic                w_guard_nxt;
    logic                r_mem_timeout;
    logic                w_flush_evt;

    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_flush;
    logic w_pipe_en;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_run;
            r_wait_cnt    <= '0;
            r_guard       <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_guard    <= w_guard_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_set  = 1'b0;
        case (r_state)
            c_st_run: begin
                if (mem_busy) begin
                    w_next_state   = c_st_wait;
                    w_wait_cnt_nxt = c_wcnt_w'(1);
                end
            end
            c_st_wait: begin
                if (!mem_busy) begin
                    w_next_state = c_st_run;
                end else if (r_wait_cnt >= c_wait_last) begin
                    w_next_state   = c_st_halt;
                    w_wait_cnt_nxt = r_wait_cnt + c_wcnt_w'(1);
                    w_timeout_set  = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_wcnt_w'(1);
                end
            end
            c_st_halt: begin
                w_next_state = c_st_halt;
            end
            default: begin
                w_next_state = c_st_run;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mealy output logic. A WAIT cycle with mem_busy low already follows
    // the RUN rules, so "not halted and not busy" selects the RUN table.
    // The guard is held across freezes so a deferred load-use still gets
    // its single bubble once memory completes.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_pipe_en      = 1'b0;
        w_guard_nxt    = r_guard;
        w_flush_evt    = 1'b0;

        if (reset) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
        end else if ((r_state != c_st_halt) && !mem_busy) begin
            if (branch_taken_mem) begin
                // Flush wins over load-use: the stalled instruction is
                // squashed by the flush anyway.
                w_pc_write     = 1'b1;
                w_if_id_write  = 1'b1;
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
                w_ex_mem_flush = 1'b1;
                w_pipe_en      = 1'b1;
                w_guard_nxt    = 1'b0;
                w_flush_evt    = 1'b1;
            end else if (load_use && !r_guard) begin
                w_id_ex_flush = 1'b1;
                w_pipe_en     = 1'b1;
                w_guard_nxt   = 1'b1;
            end else begin
                w_pc_write    = 1'b1;
                w_if_id_write = 1'b1;
                w_pipe_en     = 1'b1;
                w_guard_nxt   = 1'b0;
            end
        end
    end

    assign pc_write     = w_pc_write;
    assign if_id_write  = w_if_id_write;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_flush  = w_id_ex_flush;
    assign ex_mem_flush = w_ex_mem_flush;
    assign pipe_en      = w_pipe_en;
    assign mem_timeout  = r_mem_timeout;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (!reset && !w_pc_write),
        .o_count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_flush_evt),
        .o_count (flush_events)
    );

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl with
//               WAIT_MAX=4 and CNT_W=4 so timeout and counter saturation
//               are reachable in a few cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;

    // Control bundle: {pc_write, if_id_write, if_id_flush, id_ex_flush,
    //                  ex_mem_flush, pipe_en}
    localparam logic [5:0] c_ctl_run    = 6'b110001;
    localparam logic [5:0] c_ctl_freeze = 6'b000000;
    localparam logic [5:0] c_ctl_reset  = 6'b001110;
    localparam logic [5:0] c_ctl_bubble = 6'b000101;
    localparam logic [5:0] c_ctl_branch = 6'b111111;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_use;
    logic             branch_taken_mem;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pipe_en;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [5:0]       w_ctl;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .load_use         (load_use),
        .branch_taken_mem (branch_taken_mem),
        .mem_busy         (mem_busy),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .pipe_en          (pipe_en),
        .mem_timeout      (mem_timeout),
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events)
    );

    assign w_ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                    ex_mem_flush, pipe_en};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle and move to the falling edge to sample
    task automatic cyc(input logic r, input logic lu, input logic br,
                       input logic mb);
        reset            = r;
        load_use         = lu;
        branch_taken_mem = br;
        mem_busy         = mb;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        load_use         = 1'b0;
        branch_taken_mem = 1'b0;
        mem_busy         = 1'b0;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_ctl", 32'(w_ctl), 32'(c_ctl_reset));
        adv();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        adv();

        // 1: idle
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_ctl", 32'(w_ctl), 32'(c_ctl_run));
            adv();
        end
        chk("idle_stall", 32'(stall_cycles), 32'd0);
        chk("idle_flush", 32'(flush_events), 32'd0);
        chk("idle_tmo", 32'(mem_timeout), 32'd0);

        // 2: load-use held two cycles -> exactly one bubble
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lu_bubble", 32'(w_ctl), 32'(c_ctl_bubble));
        adv();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lu_second", 32'(w_ctl), 32'(c_ctl_run));
        chk("lu_stall", 32'(stall_cycles), 32'd1);
        adv();

        // 3: branch + load-use together
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("br_lu_ctl", 32'(w_ctl), 32'(c_ctl_branch));
        adv();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_after", 32'(w_ctl), 32'(c_ctl_run));
        chk("br_flush", 32'(flush_events), 32'd1);
        chk("br_stall", 32'(stall_cycles), 32'd1);
        adv();

        // 4: memory busy defers a held branch
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            chk("busy_frz", 32'(w_ctl), 32'(c_ctl_freeze));
            adv();
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("busy_br", 32'(w_ctl), 32'(c_ctl_branch));
        chk("busy_stall", 32'(stall_cycles), 32'd4);
        chk("busy_flush0", 32'(flush_events), 32'd1);
        adv();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_after", 32'(w_ctl), 32'(c_ctl_run));
        chk("busy_flush", 32'(flush_events), 32'd2);
        adv();

        // 5: timeout after WAIT_MAX busy cycles
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk("tmo_frz", 32'(w_ctl), 32'(c_ctl_freeze));
            chk("tmo_pre", 32'(mem_timeout), 32'd0);
            adv();
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("tmo_set", 32'(mem_timeout), 32'd1);
        chk("tmo_frz2", 32'(w_ctl), 32'(c_ctl_freeze));
        adv();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_frz", 32'(w_ctl), 32'(c_ctl_freeze));
        chk("halt_tmo", 32'(mem_timeout), 32'd1);
        chk("halt_stall", 32'(stall_cycles), 32'd9);
        adv();

        // 6: saturation while halted
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk("halt_br_frz", 32'(w_ctl), 32'(c_ctl_freeze));
            adv();
        end
        chk("sat_stall", 32'(stall_cycles), 32'hF);
        chk("sat_flush", 32'(flush_events), 32'd2);

        // Reset leaves HALT and clears the sticky error
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_ctl", 32'(w_ctl), 32'(c_ctl_reset));
        adv();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_run", 32'(w_ctl), 32'(c_ctl_run));
        chk("rst_tmo", 32'(mem_timeout), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_flush", 32'(flush_events), 32'd0);
        adv();

        // Reset in the middle of WAIT
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            adv();
        end
        chk("mw_stall", 32'(stall_cycles), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mw_rst_ctl", 32'(w_ctl), 32'(c_ctl_reset));
        adv();
        // A fresh wait count must tolerate three more busy cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk("mw_frz", 32'(w_ctl), 32'(c_ctl_freeze));
            chk("mw_cnt", 32'(stall_cycles), 32'(i));
            adv();
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mw_run", 32'(w_ctl), 32'(c_ctl_run));
        chk("mw_tmo", 32'(mem_timeout), 32'd0);
        chk("mw_stall3", 32'(stall_cycles), 32'd3);
        adv();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
